// File: rtl/fadd_arbiter.sv
// rtl/fadd_arbiter.sv - round-robin arbiter sharing one multi-cycle float adder
//
// Purpose:
//    Shares a single multi-cycle single-precision float adder among N
//    requesters. One operation is in flight at a time. The winner's operands
//    are captured and held on fa_a/fa_b, a one-cycle fa_start is issued, the
//    arbiter waits for fa_done, and the sum is returned to the granted
//    requester over a valid/ready response.
//
// Optional feature macro: FADD_ARB_TIMEOUT_EN
//    When defined, WAIT is bounded to TIMEOUT cycles. On expiry, a NaN
//    (32'h7F800001) is returned with rsp_err=1. When undefined, WAIT holds
//    until fa_done and rsp_err is tied to 0.
//
// Ports:
//    clk        in   1      clock, rising edge
//    rst        in   1      asynchronous reset, active-high
//    req_valid  in   N      requester i has operands pending
//    req_a      in   32*N   operand a, requester i at [32*i+31:32*i]
//    req_b      in   32*N   operand b, same packing
//    req_ready  out  N      one-hot; operands of i accepted this cycle
//    rsp_valid  out  N      one-hot; result for requester i is on rsp_c
//    rsp_ready  in   N      requester i takes its result
//    rsp_c      out  32     result word
//    rsp_err    out  1      result is a timeout abort (qualified by rsp_valid)
//    fa_a       out  32     adder operand a, held from ISSUE through WAIT
//    fa_b       out  32     adder operand b, same
//    fa_start   out  1      one-cycle start pulse to the adder
//    fa_done    in   1      adder result valid, one-cycle pulse
//    fa_c       in   32     adder result, sampled only on fa_done in WAIT

module fadd_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_valid,
   input  logic [32*N-1:0] req_a,
   input  logic [32*N-1:0] req_b,
   output logic [N-1:0]    req_ready,
   output logic [N-1:0]    rsp_valid,
   input  logic [N-1:0]    rsp_ready,
   output logic [31:0]     rsp_c,
   output logic            rsp_err,
   output logic [31:0]     fa_a,
   output logic [31:0]     fa_b,
   output logic            fa_start,
   input  logic            fa_done,
   input  logic [31:0]     fa_c
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if (N < 1 || N > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("fadd_arbiter: N must be 1..8 and TIMEOUT at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] last;
   logic [IW-1:0] gnt;
   logic [IW-1:0] win;
   logic          win_vld;
   logic          timeout_hit;

   // Round-robin search starting just after the last served requester, so a
   // requester granted last has the lowest priority in the next round.
   always_comb begin
      int idx;
      idx     = 0;
      win     = '0;
      win_vld = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last) + k) % N;
         if (!win_vld && req_valid[idx]) begin
            win     = IW'(idx);
            win_vld = 1'b1;
         end
      end
   end

   // Handshake outputs decode straight from state; req_ready is also gated by
   // rst so that nothing is offered while reset is held.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int i = 0; i < N; i++) begin
         req_ready[i] = !rst && (state == S_IDLE) && win_vld && (win == IW'(i));
         rsp_valid[i] = (state == S_RESP) && (gnt == IW'(i));
      end
   end

   assign fa_start = (state == S_ISSUE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; fa_done is only meaningful in WAIT.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (win_vld) begin
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (fa_done || timeout_hit) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready[gnt]) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef FADD_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;

   logic [CW-1:0] wait_cnt;
   logic          rsp_err_q;

   // wait_cnt holds the number of WAIT cycles already elapsed, so the abort
   // fires at the end of the TIMEOUT-th WAIT cycle.
   assign timeout_hit = (state == S_WAIT) && !fa_done && (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == S_ISSUE) begin
         wait_cnt <= '0;
      end else if (state == S_WAIT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   // Datapath: operand capture, result capture, rotation pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last  <= IW'(N - 1);
         gnt   <= '0;
         fa_a  <= '0;
         fa_b  <= '0;
         rsp_c <= '0;
`ifdef FADD_ARB_TIMEOUT_EN
         rsp_err_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (win_vld) begin
                  gnt  <= win;
                  fa_a <= req_a[32*win +: 32];
                  fa_b <= req_b[32*win +: 32];
               end
            end
            S_WAIT: begin
               if (fa_done) begin
                  rsp_c <= fa_c;
`ifdef FADD_ARB_TIMEOUT_EN
                  rsp_err_q <= 1'b0;
`endif
               end else if (timeout_hit) begin
                  rsp_c <= 32'h7F80_0001;
`ifdef FADD_ARB_TIMEOUT_EN
                  rsp_err_q <= 1'b1;
`endif
               end
            end
            S_RESP: begin
               if (rsp_ready[gnt]) begin
                  last <= gnt;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fadd_arbiter.sv
// tb/tb_fadd_arbiter.sv - self-checking bench for fadd_arbiter with scoreboard and adder model
module tb_fadd_arbiter;

   localparam int N   = 4;
   localparam int LAT = 10;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [32*N-1:0] req_a;
   logic [32*N-1:0] req_b;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [31:0]     rsp_c;
   logic            rsp_err;
   logic [31:0]     fa_a;
   logic [31:0]     fa_b;
   logic            fa_start;
   logic            fa_done;
   logic [31:0]     fa_c;

   always #5 clk = ~clk;

   fadd_arbiter #(.N(N), .TIMEOUT(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_c     (rsp_c),
      .rsp_err   (rsp_err),
      .fa_a      (fa_a),
      .fa_b      (fa_b),
      .fa_start  (fa_start),
      .fa_done   (fa_done),
      .fa_c      (fa_c)
   );

   typedef struct {
      int          idx;
      logic [31:0] c;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          grant_log[$];
   logic [31:0] a_in [N];
   logic [31:0] b_in [N];

   int   n_chk = 0;
   int   n_fail = 0;
   int   acc_cnt = 0;
   int   start_cnt = 0;
   logic acc_seen = 1'b0;
   logic start_seen = 1'b0;
   logic busy = 1'b0;
   int   lat_left = 0;
   logic model_off = 1'b0;
   logic spur_issue = 1'b0;
   logic expect_to = 1'b0;

   // Known sums of the operand pairs used in this bench.
   function automatic logic [31:0] fsum(logic [31:0] a, logic [31:0] b);
      case ({a, b})
         {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;  // 1+2=3
         {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;  // 2+2=4
         {32'h4080_0000, 32'h4080_0000}: return 32'h4100_0000;  // 4+4=8
         {32'h3F00_0000, 32'h3F00_0000}: return 32'h3F80_0000;  // .5+.5=1
         default:                        return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic int oh2i(logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      acc_seen   = |req_ready;
      start_seen = fa_start;
      if (fa_start) start_cnt++;
      if (req_ready != '0) begin
         chk("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
         e.idx = oh2i(req_ready);
         e.c   = expect_to ? 32'h7F80_0001 : fsum(a_in[e.idx], b_in[e.idx]);
         e.err = expect_to;
         sb.push_back(e);
         grant_log.push_back(e.idx);
         acc_cnt++;
      end
      if (rsp_valid != '0) begin
         chk("rsp_valid_onehot", 32'($onehot(rsp_valid)), 32'd1);
         chk("req_ready_in_resp", 32'(req_ready), 32'd0);
         if ((rsp_valid & rsp_ready) != '0) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_idx", 32'(oh2i(rsp_valid)), 32'(e.idx));
               chk("rsp_c", rsp_c, e.c);
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
         end
      end
   endtask

   // Adder model: done LAT cycles into WAIT, sum from the operands it is fed.
   task automatic adder_model();
      fa_done = 1'b0;
      if (start_seen && !model_off) begin
         busy     = 1'b1;
         lat_left = LAT;
      end else if (busy) begin
         if (lat_left == 1) begin
            fa_done = 1'b1;
            fa_c    = fsum(fa_a, fa_b);
            busy    = 1'b0;
         end else begin
            lat_left--;
         end
      end
      if (spur_issue && acc_seen) begin
         fa_done = 1'b1;
         fa_c    = 32'hBADB_AD00;
      end
   endtask

   // Inputs change just after a rising edge; sampling happens on the falling edge.
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      adder_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sb.delete();
      busy = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_acc(string tag, int budget);
      int n = 0;
      acc_seen = 1'b0;
      while (!acc_seen && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(acc_seen), 32'd1);
   endtask

   task automatic wait_rsp(string tag, int budget);
      int n = 0;
      while (rsp_valid == '0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(rsp_valid != '0), 32'd1);
   endtask

   task automatic drain(string tag, int budget);
      int n = 0;
      while ((sb.size() != 0 || busy || rsp_valid != '0) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int exp_g [5];
      int n;
      exp_g = '{0, 1, 2, 3, 0};

      a_in[0] = 32'h3F80_0000; b_in[0] = 32'h4000_0000;
      a_in[1] = 32'h4000_0000; b_in[1] = 32'h4000_0000;
      a_in[2] = 32'h4080_0000; b_in[2] = 32'h4080_0000;
      a_in[3] = 32'h3F00_0000; b_in[3] = 32'h3F00_0000;
      for (int i = 0; i < N; i++) begin
         req_a[32*i +: 32] = a_in[i];
         req_b[32*i +: 32] = b_in[i];
      end
      rst = 1'b1; req_valid = '0; rsp_ready = '0; fa_done = 1'b0; fa_c = '0;

      // Reset state
      tick();
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_fa_start", 32'(fa_start), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_c", rsp_c, 32'd0);
      chk("rst_fa_a", fa_a, 32'd0);
      chk("rst_fa_b", fa_b, 32'd0);
      rst = 1'b0;
      tick();

      // Single op on requester 0: 1.0 + 2.0
      acc_cnt = 0; start_cnt = 0;
      req_valid = 4'b0001;
      wait_acc("t1_accept", 10);
      req_valid = '0;
      wait_rsp("t1_rsp_timeout", 40);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'b0001);
      chk("t1_rsp_c", rsp_c, 32'h4040_0000);
      chk("t1_rsp_err", 32'(rsp_err), 32'd0);
      chk("t1_accept_count", 32'(acc_cnt), 32'd1);
      chk("t1_start_count", 32'(start_cnt), 32'd1);
      rsp_ready = 4'b0001;
      tick();
      rsp_ready = '0;
      tick();
      chk("t1_back_idle", 32'(rsp_valid), 32'd0);

      // All four requesting continuously from reset: grants 0,1,2,3,0
      do_reset();
      grant_log.delete();
      req_valid = 4'b1111; rsp_ready = 4'b1111;
      n = 0;
      while (grant_log.size() < 5 && n < 300) begin
         tick();
         n++;
      end
      req_valid = '0;
      drain("t2_drain", 100);
      chk("t2_grant_count", 32'(grant_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < grant_log.size()) chk($sformatf("t2_grant_%0d", i), 32'(grant_log[i]), 32'(exp_g[i]));
      end

      // Backpressure on requester 2; others' rsp_ready must be ignored
      rsp_ready = '0;
      req_valid = 4'b0100;
      wait_acc("t3_accept", 10);
      req_valid = 4'b1011;
      wait_rsp("t3_rsp_timeout", 40);
      rsp_ready = 4'b1011;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t3_hold_valid", 32'(rsp_valid), 32'b0100);
         chk("t3_hold_c", rsp_c, 32'h4100_0000);
         chk("t3_hold_no_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 4'b0100;
      tick();
      #1;
      chk("t3_idle_after_release", 32'(rsp_valid), 32'd0);
      chk("t3_next_winner", 32'(req_ready), 32'b1000);
      req_valid = '0; rsp_ready = 4'b1111;
      tick();
      drain("t3_drain", 100);

      // Reset during WAIT; late fa_done must not produce a response
      rsp_ready = 4'b1111;
      req_valid = 4'b0010;
      wait_acc("t4_accept", 10);
      req_valid = '0;
      for (int i = 0; i < 4; i++) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("t4_async_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t4_async_req_ready", 32'(req_ready), 32'd0);
      chk("t4_async_fa_start", 32'(fa_start), 32'd0);
      chk("t4_async_fa_a", fa_a, 32'd0);
      chk("t4_async_fa_b", fa_b, 32'd0);
      chk("t4_async_rsp_c", rsp_c, 32'd0);
      sb.delete();
      busy = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      fa_done = 1'b1; fa_c = 32'hBADB_AD00;
      tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
      end
      req_valid = 4'b1111;
      #1;
      chk("t4_first_grant", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      drain("t4_drain", 100);

      // Spurious fa_done in IDLE and in ISSUE
      fa_done = 1'b1; fa_c = 32'hBADB_AD00;
      tick();
      chk("t5_idle_done_ignored", 32'(rsp_valid), 32'd0);
      spur_issue = 1'b1;
      req_valid = 4'b1000;
      wait_acc("t5_accept", 10);
      spur_issue = 1'b0;
      req_valid = '0;
      tick();
      chk("t5_issue_done_ignored", 32'(rsp_valid), 32'd0);
      wait_rsp("t5_rsp_timeout", 40);
      chk("t5_rsp_c", rsp_c, 32'h3F80_0000);
      drain("t5_drain", 100);

`ifdef FADD_ARB_TIMEOUT_EN
      // Adder never finishes: abort after 64 WAIT cycles
      rsp_ready = '0;
      model_off = 1'b1; expect_to = 1'b1;
      req_valid = 4'b0001;
      wait_acc("t6_accept", 10);
      req_valid = '0; expect_to = 1'b0;
      n = 0;
      while (rsp_valid == '0 && n < 200) begin
         tick();
         n++;
      end
      chk("t6_abort_cycles", 32'(n), 32'd65);
      chk("t6_rsp_c", rsp_c, 32'h7F80_0001);
      chk("t6_rsp_err", 32'(rsp_err), 32'd1);
      fa_done = 1'b1; fa_c = 32'hBADB_AD00;
      tick();
      chk("t6_late_done_valid", 32'(rsp_valid), 32'b0001);
      chk("t6_late_done_c", rsp_c, 32'h7F80_0001);
      rsp_ready = 4'b1111;
      tick();
      model_off = 1'b0;
      req_valid = 4'b0001;
      wait_acc("t6_next_accept", 10);
      req_valid = '0;
      wait_rsp("t6_next_rsp_timeout", 40);
      chk("t6_next_err", 32'(rsp_err), 32'd0);
      chk("t6_next_c", rsp_c, 32'h4040_0000);
      drain("t6_drain", 100);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
